// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//
// Registered execute stage. Single-cycle ops (add/sub/logic/shift) land in
// Result one edge after Start. Signed MULT (shift-add) and, when built with
// ALU_DIVIDER_EN, signed DIV (restoring) iterate WIDTH cycles on operand
// magnitudes, then a FINISH cycle applies signs and writes HI/LO/Result.
//
// Configuration macro: ALU_DIVIDER_EN
//   defined   -> code 0011 is a signed iterative divide
//   undefined -> code 0011 is an unsupported single-cycle code (Result = 0)
//
// Handshake: Start is sampled only in IDLE. Busy is high while a multi-cycle
// op is in flight; Start is ignored then. Done is a one-cycle pulse on the
// edge that writes the result (single-cycle op or FINISH).
//
// Ports:
//   clock, reset      clock / async active-high reset
//   ALU_control [3:0] operation code
//   Operand_A   [W]   rs; dividend / multiplicand
//   Operand_B   [W]   rt; divisor / multiplier / shift source
//   Shamt       [5]   shift amount
//   Start             launch request
//   Result      [W]   registered result
//   HI, LO      [W]   product halves / remainder, quotient
//   Zero              Result == 0 (combinational)
//   Busy, Done        handshake status
//   fsm_state   [2]   debug view of the FSM state (0 IDLE,1 MULT,2 DIV,3 FINISH)
// -----------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       ALU_control,
    input  logic [WIDTH-1:0] Operand_A,
    input  logic [WIDTH-1:0] Operand_B,
    input  logic [4:0]       Shamt,
    input  logic             Start,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Zero,
    output logic             Busy,
    output logic             Done,
    output logic [1:0]       fsm_state
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MULT = 4'b0010;
`ifdef ALU_DIVIDER_EN
    localparam logic [3:0] OP_DIV  = 4'b0011;
`endif
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MULT   = 2'd1,
        DIV    = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    // Shared iteration registers:
    //   MULT: acc_hi = partial product upper half, acc_lo = multiplier / product low
    //   DIV:  acc_hi = partial remainder,          acc_lo = dividend / quotient
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    // Multiplicand magnitude (MULT) or divisor magnitude (DIV)
    logic [WIDTH-1:0] operand_mag;
    // Final result negated when operand signs differ
    logic             sign_neg;
`ifdef ALU_DIVIDER_EN
    logic             is_div;
    logic             sign_a;     // remainder takes the dividend's sign
    logic [WIDTH-1:0] a_saved;    // original dividend, returned in HI on divide by zero
    logic             b_zero;
`endif

    assign fsm_state = state;
    assign Zero      = (Result == '0);

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH-1:0] single_result;
    always_comb begin
        single_result = '0;
        case (ALU_control)
            OP_ADD:  single_result = Operand_A + Operand_B;
            OP_SUB:  single_result = Operand_A - Operand_B;
            OP_SLL:  single_result = Operand_B << Shamt;
            OP_SRL:  single_result = Operand_B >> Shamt;
            OP_AND:  single_result = Operand_A & Operand_B;
            OP_OR:   single_result = Operand_A | Operand_B;
            OP_XOR:  single_result = Operand_A ^ Operand_B;
            OP_NOR:  single_result = ~(Operand_A | Operand_B);
            default: single_result = '0;
        endcase
    end

    // ---------------- multiplier step ----------------
    // Add the multiplicand when the current multiplier LSB is set, then the
    // whole {carry, acc_hi, acc_lo} shifts right by one.
    logic [WIDTH:0] mult_sum;
    always_comb begin
        mult_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_mag} : {(WIDTH+1){1'b0}});
    end

`ifdef ALU_DIVIDER_EN
    // ---------------- divider step ----------------
    // Shift the next dividend bit into the remainder and try subtracting the
    // divisor; a borrow (MSB set) means restore and emit a 0 quotient bit.
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_trial;
    always_comb begin
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_trial = div_shift - {1'b0, operand_mag};
    end
`endif

    // ---------------- sign fix-up at FINISH ----------------
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;
    always_comb begin
        prod_mag    = {acc_hi, acc_lo};
        prod_signed = sign_neg ? (~prod_mag + 1'b1) : prod_mag;
        fin_hi      = prod_signed[2*WIDTH-1:WIDTH];
        fin_lo      = prod_signed[WIDTH-1:0];
`ifdef ALU_DIVIDER_EN
        if (is_div) begin
            if (b_zero) begin
                fin_hi = a_saved;
                fin_lo = '1;
            end else begin
                fin_lo = sign_neg ? (~acc_lo + 1'b1) : acc_lo;
                fin_hi = sign_a   ? (~acc_hi + 1'b1) : acc_hi;
            end
        end
`endif
    end

    // ---------------- FSM and registered outputs ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            operand_mag <= '0;
            sign_neg    <= 1'b0;
            Result      <= '0;
            HI          <= '0;
            LO          <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
`ifdef ALU_DIVIDER_EN
            is_div      <= 1'b0;
            sign_a      <= 1'b0;
            a_saved     <= '0;
            b_zero      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        case (ALU_control)
                            OP_MULT: begin
                                operand_mag <= magnitude(Operand_A);
                                acc_hi      <= '0;
                                acc_lo      <= magnitude(Operand_B);
                                sign_neg    <= Operand_A[WIDTH-1] ^ Operand_B[WIDTH-1];
                                cnt         <= '0;
                                Busy        <= 1'b1;
`ifdef ALU_DIVIDER_EN
                                is_div      <= 1'b0;
`endif
                                state       <= MULT;
                            end
`ifdef ALU_DIVIDER_EN
                            OP_DIV: begin
                                operand_mag <= magnitude(Operand_B);
                                acc_hi      <= '0;
                                acc_lo      <= magnitude(Operand_A);
                                sign_neg    <= Operand_A[WIDTH-1] ^ Operand_B[WIDTH-1];
                                sign_a      <= Operand_A[WIDTH-1];
                                a_saved     <= Operand_A;
                                b_zero      <= (Operand_B == '0);
                                is_div      <= 1'b1;
                                cnt         <= '0;
                                Busy        <= 1'b1;
                                state       <= DIV;
                            end
`endif
                            default: begin
                                Result <= single_result;
                                Done   <= 1'b1;
                            end
                        endcase
                    end
                end

                MULT: begin
                    acc_hi <= mult_sum[WIDTH:1];
                    acc_lo <= {mult_sum[0], acc_lo[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) state <= FINISH;
                end

                DIV: begin
`ifdef ALU_DIVIDER_EN
                    if (div_trial[WIDTH]) begin
                        acc_hi <= div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                    end else begin
                        acc_hi <= div_trial[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) state <= FINISH;
`else
                    // Unreachable without the divider; recover to IDLE.
                    Busy  <= 1'b0;
                    state <= IDLE;
`endif
                end

                FINISH: begin
                    HI     <= fin_hi;
                    LO     <= fin_lo;
                    Result <= fin_lo;
                    Done   <= 1'b1;
                    Busy   <= 1'b0;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Directed plus randomized stimulus against a behavioural model built on plain
// signed arithmetic. Handles both builds (ALU_DIVIDER_EN defined or not).
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

    localparam int WIDTH = 32;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    always #5 clock = ~clock;

    logic [3:0]  alu_control = '0;
    logic [31:0] operand_a   = '0;
    logic [31:0] operand_b   = '0;
    logic [4:0]  shamt       = '0;
    logic        start       = 1'b0;
    logic [31:0] result, hi, lo;
    logic        zero, busy, done;
    logic [1:0]  fsm_state;

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .ALU_control (alu_control),
        .Operand_A   (operand_a),
        .Operand_B   (operand_b),
        .Shamt       (shamt),
        .Start       (start),
        .Result      (result),
        .HI          (hi),
        .LO          (lo),
        .Zero        (zero),
        .Busy        (busy),
        .Done        (done),
        .fsm_state   (fsm_state)
    );

    // ---------------- scoreboard ----------------
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic bit is_multi(input logic [3:0] code);
`ifdef ALU_DIVIDER_EN
        return (code == 4'd2) || (code == 4'd3);
`else
        return (code == 4'd2);
`endif
    endfunction

    // Reference model: returns the expected Result and updates the HI/LO model.
    task automatic model(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output logic [31:0] res);
        longint sa, sb, p, q, r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = '0;
        case (code)
            4'd0:  res = a + b;
            4'd1:  res = a - b;
            4'd2: begin
                p    = sa * sb;
                hi_m = p[63:32];
                lo_m = p[31:0];
                res  = lo_m;
            end
`ifdef ALU_DIVIDER_EN
            4'd3: begin
                if (b == 0) begin
                    hi_m = a;
                    lo_m = 32'hFFFF_FFFF;
                end else begin
                    q    = sa / sb;
                    r    = sa % sb;
                    hi_m = r[31:0];
                    lo_m = q[31:0];
                end
                res = lo_m;
            end
`endif
            4'd4:  res = b << sh;
            4'd5:  res = b >> sh;
            4'd8:  res = a & b;
            4'd9:  res = a | b;
            4'd10: res = a ^ b;
            4'd11: res = ~(a | b);
            default: res = '0;
        endcase
    endtask

    // ---------------- driver tasks ----------------
    // All drivers are entered and left at #1 after a rising edge.
    task automatic do_single(input logic [3:0] code, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] e;
        model(code, a, b, sh, e);
        exp_q.push_back(e);
        alu_control = code; operand_a = a; operand_b = b; shamt = sh; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        e = exp_q.pop_front();
        check("single_result", result, e);
        check("single_done", 32'(done), 32'd1);
        check("single_busy", 32'(busy), 32'd0);
        check("single_zero", 32'(zero), 32'(e == 0));
        check("single_hi", hi, hi_m);
        check("single_lo", lo, lo_m);
    endtask

    // inject >= 0: pulse Start with an add that many edges after launch.
    task automatic do_multi(input logic [3:0] code, input logic [31:0] a,
                            input logic [31:0] b, input int inject);
        logic [31:0] e;
        int          cycles;
        bit          busy_ok;
        model(code, a, b, 5'd0, e);
        exp_q.push_back(e);
        alu_control = code; operand_a = a; operand_b = b; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        // operands are captured at launch; scramble them afterwards
        operand_a = $urandom; operand_b = $urandom;
        check("multi_busy_launch", 32'(busy), 32'd1);
        check("multi_done_launch", 32'(done), 32'd0);
        cycles  = 0;
        busy_ok = 1'b1;
        while (!done && cycles < WIDTH + 8) begin
            if (cycles == inject) begin
                start = 1'b1; alu_control = 4'd0;
            end else if (inject >= 0 && cycles == inject + 1) begin
                start = 1'b0;
            end
            @(posedge clock); #1;
            cycles++;
            if (!done && !busy) busy_ok = 1'b0;
        end
        start = 1'b0;
        e = exp_q.pop_front();
        check("multi_latency", 32'(cycles), 32'(WIDTH + 1));
        check("multi_busy_run", 32'(busy_ok), 32'd1);
        check("multi_busy_done", 32'(busy), 32'd0);
        check("multi_result", result, e);
        check("multi_hi", hi, hi_m);
        check("multi_lo", lo, lo_m);
    endtask

    task automatic run_op(input logic [3:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input int inject);
        if (is_multi(code)) do_multi(code, a, b, inject);
        else                do_single(code, a, b, sh);
    endtask

    task automatic idle_cycle_done_clear(input string tag);
        @(posedge clock); #1;
        check(tag, 32'(done), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    logic [3:0] code_tbl[14] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8,
                                 4'd9, 4'd10, 4'd11, 4'd6, 4'd7, 4'd12, 4'd15};

    initial begin
        logic [31:0] a, b;
        logic [3:0]  c;

        #23 reset = 1'b0;
        @(posedge clock); #1;
        check("rst_result", result, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_state", 32'(fsm_state), 32'd0);

        // single-cycle ops, back to back
        run_op(4'd0,  32'h7FFF_FFFF, 32'd1, 5'd0, -1);
        run_op(4'd1,  32'd5, 32'd5, 5'd0, -1);
        run_op(4'd4,  32'h0, 32'h0000_000F, 5'd4, -1);
        run_op(4'd5,  32'h0, 32'h8000_0000, 5'd31, -1);
        run_op(4'd11, 32'h0, 32'h0, 5'd0, -1);
        idle_cycle_done_clear("done_clear_single");

        // multiply, then verify Done was a single pulse
        run_op(4'd2, 32'hFFFF_FFFD, 32'd7, 5'd0, -1);
        idle_cycle_done_clear("done_clear_multi");

        // division corner cases (code 3 is single-cycle zero without divider)
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 5'd0, -1);
        run_op(4'd3, 32'd7, 32'd0, 5'd0, -1);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, -1);
        run_op(4'd3, 32'd100, 32'hFFFF_FFF9, 5'd0, -1);

        // Start while busy is ignored; Start in the Done cycle is accepted
        run_op(4'd2, 32'h1234_5678, 32'hFEDC_BA98, 5'd0, 10);
        run_op(4'd0, 32'd40, 32'd2, 5'd0, -1);

        // reset in the middle of a multiply
        alu_control = 4'd2; operand_a = 32'hDEAD_BEEF; operand_b = 32'h0000_1234; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (14) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("abort_result", result, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        hi_m = '0; lo_m = '0;
        #2 reset = 1'b0;
        @(posedge clock); #1;
        check("abort_state", 32'(fsm_state), 32'd0);
        run_op(4'd0, 32'd3, 32'd4, 5'd0, -1);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            c = code_tbl[$urandom_range(13, 0)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(5, 0))
                0: b = 32'd0;
                1: b = $urandom_range(9, 0);
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: a = -($urandom_range(1000, 0));
                default: ;
            endcase
            run_op(c, a, b, 5'($urandom_range(31, 0)), -1);
        end
        idle_cycle_done_clear("done_clear_final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
